// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory port, execute-stage controls,
// and the decode-side valid/ready output with status counters.
interface instruction_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic [31:0] fetch_count;

  // Fetch unit side
  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted,
    output fetch_count
  );

  // Memory / execute / decode side
  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted,
    input  fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction
// memory, buffers {pc, instr} pairs in a small FIFO and hands them to decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_q_pc    [QUEUE_DEPTH];
  logic [31:0]       r_q_instr [QUEUE_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_out_pc;
  logic [31:0]       r_out_instr;
  logic [31:0]       r_fetch_count;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic [PTR_W-1:0]  w_head_next;
  logic [CNT_W-1:0]  w_remain;
  logic [31:0]       w_out_pc_next;
  logic [31:0]       w_out_instr_next;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Redirect wins over everything: the head shown in that cycle is not consumed.
  assign w_pop  = ~w_empty & bus.out_ready & ~bus.redirect_valid;
  assign w_push = (r_state == RUN) & ~bus.halt_req & ~bus.redirect_valid & (~w_full | w_pop);

  assign w_head_next = r_head + PTR_W'(w_pop);
  assign w_remain    = r_count - CNT_W'(w_pop);

  // Next head value: the output registers mirror the FIFO head one edge ahead,
  // taking the incoming word directly when the queue would otherwise be empty,
  // and holding the last value when nothing remains.
  always_comb begin
    w_out_pc_next    = r_out_pc;
    w_out_instr_next = r_out_instr;
    if (w_remain != '0) begin
      w_out_pc_next    = r_q_pc[w_head_next];
      w_out_instr_next = r_q_instr[w_head_next];
    end else if (w_push) begin
      w_out_pc_next    = r_fetch_pc;
      w_out_instr_next = bus.imem_data;
    end
  end

  // Run/halt next-state; a redirect leaves the state untouched.
  always_comb begin
    w_state_next = r_state;
    if (!bus.redirect_valid) begin
      case (r_state)
        RUN:     if (bus.halt_req)  w_state_next = HALTED;
        HALTED:  if (!bus.halt_req) w_state_next = RUN;
        default: w_state_next = RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  // PC, FIFO pointers/occupancy, output head registers and handshake counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= {RESET_PC[31:2], 2'b00};
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_out_pc      <= '0;
      r_out_instr   <= '0;
      r_fetch_count <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_tail     <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      r_head      <= w_head_next;
      r_count     <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_out_pc    <= w_out_pc_next;
      r_out_instr <= w_out_instr_next;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (w_push) begin
      r_q_pc[r_tail]    <= r_fetch_pc;
      r_q_instr[r_tail] <= bus.imem_data;
    end
  end

  assign bus.imem_addr   = {r_fetch_pc[31:2], 2'b00};
  assign bus.out_valid   = ~w_empty;
  assign bus.out_pc      = r_out_pc;
  assign bus.out_instr   = r_out_instr;
  assign bus.halted      = (r_state == HALTED) & w_empty;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus queues the
// expected {pc, instr} stream; a negedge monitor checks every handshake.
module tb_instruction_fetch_unit;

  logic clk;
  logic rst;

  instruction_fetch_unit_if bif();

  instruction_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bif)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Instruction memory model: word at byte address a is 0x1000 + a/4.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + {2'b00, a[31:2]};
  endfunction

  assign bif.imem_data = mem_word(bif.imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted head is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bif.out_valid && bif.out_ready && !bif.redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_handshake actual_pc=%h actual_instr=%h expected=none", bif.out_pc, bif.out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hs_pc", bif.out_pc, e.pc);
        chk("hs_instr", bif.out_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst                = 1'b1;
    bif.redirect_valid = 1'b0;
    bif.redirect_pc    = '0;
    bif.halt_req       = 1'b0;
    bif.out_ready      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_imem_addr", bif.imem_addr, 32'h0);
    chk("rst_halted", 32'(bif.halted), 32'd0);
    chk("rst_fetch_count", bif.fetch_count, 32'd0);
    chk("rst_out_pc", bif.out_pc, 32'h0);
    chk("rst_out_instr", bif.out_instr, 32'h0);

    // First-fetch latency with decode stalled
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("first_valid", 32'(bif.out_valid), 32'd1);
    chk("first_pc", bif.out_pc, 32'h0);
    chk("first_instr", bif.out_instr, 32'h1000);

    // Queue full, head stable, PC stuck
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("full_imem_addr", bif.imem_addr, 32'h8);
    chk("full_out_pc", bif.out_pc, 32'h0);
    chk("full_out_valid", 32'(bif.out_valid), 32'd1);

    // Release: ten back-to-back handshakes
    for (int i = 0; i < 10; i++) exp_push(32'(4 * i), 32'h1000 + 32'(i));
    @(posedge clk);
    #1 bif.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 bif.out_ready = 1'b0;
    @(negedge clk);
    chk("stream_count", bif.fetch_count, 32'd10);
    chk("stream_head_pc", bif.out_pc, 32'h28);
    chk("stream_head_instr", bif.out_instr, 32'h100A);

    // Redirect with a full queue and ready high: head not consumed
    @(posedge clk);
    #1;
    bif.out_ready      = 1'b1;
    bif.redirect_valid = 1'b1;
    bif.redirect_pc    = 32'h13;
    @(posedge clk);
    #1 bif.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_out_valid", 32'(bif.out_valid), 32'd0);
    chk("redir_out_pc_hold", bif.out_pc, 32'h28);
    chk("redir_count", bif.fetch_count, 32'd10);
    chk("redir_imem_addr", bif.imem_addr, 32'h10);
    exp_push(32'h10, 32'h1004);
    exp_push(32'h14, 32'h1005);
    exp_push(32'h18, 32'h1006);
    exp_push(32'h1C, 32'h1007);
    exp_push(32'h20, 32'h1008);

    // Halt: queue drains, PC frozen
    repeat (3) @(posedge clk);
    #1 bif.halt_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("halt_halted", 32'(bif.halted), 32'd1);
    chk("halt_out_valid", 32'(bif.out_valid), 32'd0);
    chk("halt_imem_addr", bif.imem_addr, 32'h1C);
    repeat (3) @(posedge clk);
    #1;
    chk("halt_imem_addr_late", bif.imem_addr, 32'h1C);
    chk("halt_halted_late", 32'(bif.halted), 32'd1);
    bif.halt_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("resume_halted", 32'(bif.halted), 32'd0);
    chk("resume_out_valid", 32'(bif.out_valid), 32'd0);

    // Redirect near the top of the address space: PC wraps to zero
    repeat (3) @(posedge clk);
    #1;
    bif.redirect_valid = 1'b1;
    bif.redirect_pc    = 32'hFFFF_FFF8;
    exp_push(32'hFFFF_FFF8, 32'h4000_0FFE);
    exp_push(32'hFFFF_FFFC, 32'h4000_0FFF);
    exp_push(32'h0000_0000, 32'h0000_1000);
    @(posedge clk);
    #1 bif.redirect_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 bif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wrap_imem_addr", bif.imem_addr, 32'hC);
    chk("wrap_head_pc", bif.out_pc, 32'h4);
    chk("wrap_head_instr", bif.out_instr, 32'h1001);
    chk("wrap_count", bif.fetch_count, 32'd18);

    // Asynchronous reset mid-cycle with a full queue
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("arst_imem_addr", bif.imem_addr, 32'h0);
    chk("arst_fetch_count", bif.fetch_count, 32'd0);
    chk("arst_halted", 32'(bif.halted), 32'd0);
    chk("arst_out_pc", bif.out_pc, 32'h0);

    // Restart: eight handshakes in order
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) exp_push(32'(4 * i), 32'h1000 + 32'(i));
    rst           = 1'b0;
    bif.out_ready = 1'b1;
    repeat (9) @(posedge clk);
    #1 bif.out_ready = 1'b0;
    @(negedge clk);
    chk("restart_count", bif.fetch_count, 32'd8);
    chk("restart_head_pc", bif.out_pc, 32'h20);
    chk("restart_out_valid", 32'(bif.out_valid), 32'd1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
